// File: rtl/lc3_pkg.sv
// ---------------------------------------------------------------------------
// lc3_pkg
// Shared LC-3 datapath types for the memory-access stage.
//   word_t      : 16-bit machine word
//   mem_op_t    : memory operation encoding as driven on mem_op
//   mem_state_t : memory-access sequencing FSM states
// Helpers classify an operation as store and/or indirect.
// ---------------------------------------------------------------------------
package lc3_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    STORE     = 2'd1,
    LOAD_IND  = 2'd2,
    STORE_IND = 2'd3
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IND_RD = 2'd1,
    ACCESS = 2'd2
  } mem_state_t;

  function automatic logic is_store(input mem_op_t op);
    return (op == STORE) || (op == STORE_IND);
  endfunction

  function automatic logic is_indirect(input mem_op_t op);
    return (op == LOAD_IND) || (op == STORE_IND);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// ---------------------------------------------------------------------------
// mem_watchdog
// Counts consecutive cycles a memory request waits without acknowledge and
// flags expiry on the cycle the TIMEOUT_CYCLES-th such wait occurs.
//   clock    : stage clock
//   reset    : synchronous, active-high
//   clear    : restart the count (a new request is rising)
//   count_en : request high and no ack this cycle
//   expired  : this waiting cycle is the TIMEOUT_CYCLES-th one
// ---------------------------------------------------------------------------
module mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // count_q holds the number of waiting cycles already elapsed, so the
  // current waiting cycle is number count_q+1.
  assign expired = count_en && (count_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (count_en && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// LC-3 memory-access stage: direct/indirect loads and stores against a
// variable-latency data memory over a req/ack handshake.
//   clock, reset            : stage clock, synchronous active-high reset
//   start, mem_op           : operation request (sampled only when idle)
//   M_Addr, M_Data          : effective address / store data from execute
//   busy, done              : in-progress flag, one-cycle completion pulse
//   memout                  : last loaded word, held until the next load
//   error                   : sticky timeout flag
//   dmem_req/we/addr/din    : memory request side
//   dmem_dout, dmem_ack     : memory response side
// Optional feature: define MEM_TIMEOUT_EN to abort requests that wait
// TIMEOUT_CYCLES cycles without ack; otherwise waits forever, error = 0.
// ---------------------------------------------------------------------------
module mem_access_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  output logic        busy,
  output logic        done,
  output logic [15:0] memout,
  output logic        error,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_din,
  input  logic [15:0] dmem_dout,
  input  logic        dmem_ack
);

  mem_state_t state_q, state_d;
  mem_op_t    op_q;
  word_t      addr_q, data_q, ptr_q, memout_q;
  logic       done_q, done_d;
  logic       accept, ptr_cap, load_cap, abort;
  logic       wd_expired;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= LOAD;
      addr_q   <= '0;
      data_q   <= '0;
      ptr_q    <= '0;
      memout_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (accept) begin
        op_q   <= mem_op_t'(mem_op);
        addr_q <= M_Addr;
        data_q <= M_Data;
      end
      if (ptr_cap) begin
        ptr_q <= dmem_dout;
      end
      if (load_cap) begin
        memout_q <= dmem_dout;
      end
    end
  end

  // Next-state logic; an ack always takes priority over a timeout.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    accept   = 1'b0;
    ptr_cap  = 1'b0;
    load_cap = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = is_indirect(mem_op_t'(mem_op)) ? IND_RD : ACCESS;
        end
      end
      IND_RD: begin
        if (dmem_ack) begin
          ptr_cap = 1'b1;
          state_d = ACCESS;
        end else if (wd_expired) begin
          abort   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          load_cap = !is_store(op_q);
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (wd_expired) begin
          abort   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state
  always_comb begin
    dmem_req  = (state_q != IDLE);
    dmem_we   = 1'b0;
    dmem_addr = addr_q;
    dmem_din  = '0;
    if (state_q == ACCESS) begin
      if (is_indirect(op_q)) begin
        dmem_addr = ptr_q;
      end
      if (is_store(op_q)) begin
        dmem_we  = 1'b1;
        dmem_din = data_q;
      end
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign memout = memout_q;

`ifdef MEM_TIMEOUT_EN
  logic wd_clear, wd_count_en, error_q;

  // A request rises on an accepted start and again when the pointer
  // read hands over to the data access.
  assign wd_clear    = accept | ptr_cap;
  assign wd_count_en = dmem_req & ~dmem_ack;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset || accept) begin
      error_q <= 1'b0;
    end else if (abort) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0) | abort;
  assign wd_expired     = 1'b0;
  assign error          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed self-checking bench for mem_access_ctrl. The bench acts as the
// data memory, answering each request with hand-chosen read data after a
// chosen number of wait cycles. All checks and stimulus happen on the
// falling edge; the DUT updates on the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mem_op;
  logic [15:0] M_Addr, M_Data;
  logic        busy, done, error;
  logic [15:0] memout;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_din, dmem_dout;
  logic        dmem_ack;

  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clock = ~clock;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .mem_op    (mem_op),
    .M_Addr    (M_Addr),
    .M_Data    (M_Data),
    .busy      (busy),
    .done      (done),
    .memout    (memout),
    .error     (error),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_dout (dmem_dout),
    .dmem_ack  (dmem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a new operation at the current falling edge for one cycle.
  task automatic issue(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] data);
    start  = 1'b1;
    mem_op = op;
    M_Addr = addr;
    M_Data = data;
    @(negedge clock);
    start  = 1'b0;
  endtask

  // Serve one request phase: request must be high now and stay stable for
  // `waits` cycles, then ack with rdata. Returns one falling edge after the
  // ack edge.
  task automatic phase(input string tag, input logic exp_we, input logic [15:0] exp_addr,
                       input logic [15:0] exp_din, input int waits, input logic [15:0] rdata);
    for (int i = 0; i <= waits; i++) begin
      chk({tag, ".req"},  {31'd0, dmem_req}, 32'd1);
      chk({tag, ".busy"}, {31'd0, busy},     32'd1);
      chk({tag, ".we"},   {31'd0, dmem_we},  {31'd0, exp_we});
      chk({tag, ".addr"}, {16'd0, dmem_addr}, {16'd0, exp_addr});
      chk({tag, ".din"},  {16'd0, dmem_din},  {16'd0, exp_din});
      chk({tag, ".done"}, {31'd0, done},     32'd0);
      if (i == waits) begin
        dmem_ack  = 1'b1;
        dmem_dout = rdata;
      end
      @(negedge clock);
    end
    dmem_ack  = 1'b0;
    dmem_dout = '0;
  endtask

  // Called in the cycle done should be high.
  task automatic check_done(input string tag, input logic [15:0] exp_memout);
    chk({tag, ".done"},   {31'd0, done},     32'd1);
    chk({tag, ".busy"},   {31'd0, busy},     32'd0);
    chk({tag, ".req"},    {31'd0, dmem_req}, 32'd0);
    chk({tag, ".memout"}, {16'd0, memout},   {16'd0, exp_memout});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed hang expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    mem_op    = 2'd0;
    M_Addr    = '0;
    M_Data    = '0;
    dmem_ack  = 1'b0;
    dmem_dout = '0;
    repeat (2) @(negedge clock);

    // Reset state
    chk("rst.busy",   {31'd0, busy},     32'd0);
    chk("rst.done",   {31'd0, done},     32'd0);
    chk("rst.req",    {31'd0, dmem_req}, 32'd0);
    chk("rst.we",     {31'd0, dmem_we},  32'd0);
    chk("rst.memout", {16'd0, memout},   32'd0);
    chk("rst.addr",   {16'd0, dmem_addr}, 32'd0);
    chk("rst.din",    {16'd0, dmem_din},  32'd0);
    chk("rst.error",  {31'd0, error},    32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle.req", {31'd0, dmem_req}, 32'd0);

    // LOAD 0x3000 -> 0x8001 after 2 wait cycles
    issue(2'd0, 16'h3000, 16'h5555);
    phase("ld", 1'b0, 16'h3000, 16'h0000, 2, 16'h8001);
    check_done("ld", 16'h8001);
    chk("ld.error", {31'd0, error}, 32'd0);
    @(negedge clock);
    chk("ld.done_once", {31'd0, done}, 32'd0);

    // STORE_IND: ptr at 0x3010 = 0x4000, write 0xBEEF there, zero waits
    issue(2'd3, 16'h3010, 16'hBEEF);
    phase("sti.rd", 1'b0, 16'h3010, 16'h0000, 0, 16'h4000);
    phase("sti.wr", 1'b1, 16'h4000, 16'hBEEF, 0, 16'hDEAD);
    check_done("sti", 16'h8001);
    @(negedge clock);
    chk("sti.done_once", {31'd0, done}, 32'd0);

    // LOAD_IND 0x3020 -> ptr 0x5000 -> 0x1234, then LOAD 0x3030 back-to-back
    issue(2'd2, 16'h3020, 16'h0000);
    phase("ldi.rd", 1'b0, 16'h3020, 16'h0000, 1, 16'h5000);
    phase("ldi.ld", 1'b0, 16'h5000, 16'h0000, 0, 16'h1234);
    check_done("ldi", 16'h1234);
    issue(2'd0, 16'h3030, 16'h0000);
    chk("b2b.done_low", {31'd0, done}, 32'd0);
    phase("b2b", 1'b0, 16'h3030, 16'h0000, 0, 16'h00AB);
    check_done("b2b", 16'h00AB);
    @(negedge clock);

    // STORE 0x3100 <- 0x1111 with a conflicting start while busy
    issue(2'd1, 16'h3100, 16'h1111);
    chk("ign.addr", {16'd0, dmem_addr}, 32'h3100);
    start  = 1'b1;
    mem_op = 2'd0;
    M_Addr = 16'h7777;
    M_Data = 16'h2222;
    @(negedge clock);
    start  = 1'b0;
    phase("ign", 1'b1, 16'h3100, 16'h1111, 1, 16'hFFFF);
    check_done("ign", 16'h00AB);
    @(negedge clock);
    chk("ign.idle", {31'd0, busy}, 32'd0);

    // Reset during IND_RD with an ack in the same cycle
    issue(2'd2, 16'h3200, 16'h0000);
    chk("rstmid.req", {31'd0, dmem_req}, 32'd1);
    reset     = 1'b1;
    dmem_ack  = 1'b1;
    dmem_dout = 16'h9999;
    @(negedge clock);
    reset     = 1'b0;
    dmem_ack  = 1'b0;
    dmem_dout = '0;
    chk("rstmid.req",    {31'd0, dmem_req}, 32'd0);
    chk("rstmid.busy",   {31'd0, busy},     32'd0);
    chk("rstmid.we",     {31'd0, dmem_we},  32'd0);
    chk("rstmid.done",   {31'd0, done},     32'd0);
    chk("rstmid.memout", {16'd0, memout},   32'd0);
    chk("rstmid.addr",   {16'd0, dmem_addr}, 32'd0);
    chk("rstmid.din",    {16'd0, dmem_din},  32'd0);
    @(negedge clock);
    chk("rstmid.no_done", {31'd0, done}, 32'd0);

    // Normal direct load after the aborted-by-reset op
    issue(2'd0, 16'h3300, 16'h0000);
    phase("post", 1'b0, 16'h3300, 16'h0000, 0, 16'h0F0F);
    check_done("post", 16'h0F0F);
    @(negedge clock);

`ifdef MEM_TIMEOUT_EN
    // No ack: abort after 4 waiting cycles
    issue(2'd0, 16'h3400, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      chk("to.req", {31'd0, dmem_req}, 32'd1);
      chk("to.err_low", {31'd0, error}, 32'd0);
      @(negedge clock);
    end
    check_done("to", 16'h0F0F);
    chk("to.error", {31'd0, error}, 32'd1);
    @(negedge clock);
    chk("to.done_once", {31'd0, done}, 32'd0);
    chk("to.sticky", {31'd0, error}, 32'd1);
    issue(2'd0, 16'h3500, 16'h0000);
    chk("to.clear", {31'd0, error}, 32'd0);
    phase("to.next", 1'b0, 16'h3500, 16'h0000, 3, 16'h0042);
    check_done("to.next", 16'h0042);
    chk("to.next_err", {31'd0, error}, 32'd0);
    @(negedge clock);
`else
    // Long wait must not abort without the watchdog
    issue(2'd0, 16'h3400, 16'h0000);
    phase("wait", 1'b0, 16'h3400, 16'h0000, 20, 16'h0042);
    check_done("wait", 16'h0042);
    chk("wait.error", {31'd0, error}, 32'd0);
    @(negedge clock);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-access stage of the LC-3 datapath, between execute and writeback. It performs direct and indirect loads and stores (LD/LDR/ST/STR and LDI/STI) against a variable-latency data memory using a req/ack handshake. It owns its sequencing FSM and reports completion to the controller with a one-cycle `done` pulse. It presents the loaded word on `memout`, which feeds the writeback stage's `memout` input when W_Control selects memory.

## Interface
- `TIMEOUT_CYCLES`, 16: req-high cycles without ack before abort; used only with `MEM_TIMEOUT_EN`.
- `clock`  in  1  stage clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  operation request; sampled only in IDLE.
- `mem_op`  in  2  0 LOAD, 1 STORE, 2 LOAD_IND, 3 STORE_IND.
- `M_Addr`  in  16  effective address from execute.
- `M_Data`  in  16  store data (source register value).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle completion pulse.
- `memout`  out  16  last loaded word; held until the next load completes.
- `error`  out  1  sticky timeout flag; constant 0 without `MEM_TIMEOUT_EN`.
- `dmem_req`  out  1  memory request; held high until acked.
- `dmem_we`  out  1  write enable; meaningful only while `dmem_req` is high.
- `dmem_addr`  out  16  memory address.
- `dmem_din`  out  16  memory write data.
- `dmem_dout`  in  16  memory read data; valid in the cycle `dmem_ack` is high.
- `dmem_ack`  in  1  memory completion; ignored when `dmem_req` is low.

## Operation
- States: IDLE, IND_RD, ACCESS.
- IDLE + `start`: latch `mem_op`, `M_Addr` and `M_Data`.
  - Ops 2 and 3 go to IND_RD.
  - Ops 0 and 1 go to ACCESS.
- IND_RD: `dmem_req`=1, `dmem_we`=0, `dmem_addr`=latched address. On ack, latch `dmem_dout` as the pointer and go to ACCESS.
- ACCESS: `dmem_req`=1. `dmem_addr` is the pointer for indirect ops, otherwise the latched address.
  - Stores: `dmem_we`=1, `dmem_din`=latched data.
  - Loads: `dmem_we`=0.
  - On ack: loads capture `dmem_dout` into `memout`; stores leave `memout` unchanged. Then pulse `done` and return to IDLE.
- `dmem_addr` and `dmem_din` hold stable while `dmem_req` is high. `dmem_din`=0 when not storing.
- `start` while busy is ignored. Inputs not latched at start have no effect mid-operation.
- `busy` = state != IDLE.
- Reset, including mid-operation, forces:
  - IDLE;
  - `dmem_req`, `dmem_we`, `done`, `busy` and `error` to 0;
  - `memout`, `dmem_addr`, `dmem_din` and the pointer to 0.
  - An ack arriving in the reset cycle is ignored.

## Timing
- All outputs are registered or decoded from registered state. No combinational path from `dmem_ack` or `dmem_dout` to any output.
- `start` sampled at edge E0: `dmem_req` rises after E0.
- Ack sampled at edge Ek: the request drops after Ek, the next phase's request (if any) rises after Ek, and `done`/`memout` update after the final ack edge.
- Minimum latency, from the start edge to the edge after which `done` is high:
  - direct ops: 2 edges (ack at E1);
  - indirect ops: 3 edges (pointer ack at E1, data ack at E2).
- `done` is high for exactly one cycle, with `busy` already low. A `start` in the `done` cycle is accepted (back-to-back operations, no bubble).
- Ack is honoured in the first cycle `dmem_req` is high (zero wait states).

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A wait counter clears on each request rise and increments each cycle `dmem_req` is high without ack.
  - When the counter reaches `TIMEOUT_CYCLES`, the operation aborts: the request drops, `error` is set, `done` pulses, the FSM returns to IDLE, and `memout` is unchanged.
  - An ack in the same cycle as the timeout wins (normal completion).
  - `error` clears on reset or the next accepted `start`.
- `MEM_TIMEOUT_EN` undefined: the block waits indefinitely, no counter logic exists, and `error` is tied 0.

## Structure
- Shared package `lc3_pkg`: `mem_op_t` enum (LOAD, STORE, LOAD_IND, STORE_IND), `mem_state_t` enum, and a 16-bit word typedef.
- The watchdog is the natural sub-module, `mem_watchdog` (clear, count-enable and expired outputs). It is instantiated only under `MEM_TIMEOUT_EN`.

## Test plan
- LOAD, `M_Addr`=0x3000, memory[0x3000]=0x8001, ack after 2 wait cycles -> `dmem_addr`=0x3000, `dmem_we`=0, `done` one cycle, `memout`=0x8001, `busy` low in the `done` cycle.
- STORE_IND, `M_Addr`=0x3010, memory[0x3010]=0x4000, `M_Data`=0xBEEF, zero-wait acks -> read at 0x3010, then write 0xBEEF to 0x4000 with `dmem_we`=1, `done` 3 edges after start, `memout` unchanged.
- LOAD_IND back-to-back with LOAD (`start` held in the `done` cycle) -> second request rises the cycle after `done`, with no idle gap.
- `start` pulsed while busy with different `mem_op`/`M_Addr` -> ignored; the in-flight address and data stay stable.
- Reset asserted in IND_RD with ack arriving the same cycle -> IDLE, all outputs 0, no `done`, pointer discarded.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, ack never arrives -> request drops after 4 wait cycles, `error`=1, `done` pulses, and the next `start` clears `error`.
